// File: rtl/axi_lite_pkg.sv
// ---------------------------------------------------------------------------
// axi_lite_pkg
// Shared definitions for the AXI4-Lite register-file slave: response codes
// and the write/read channel state encodings.
// ---------------------------------------------------------------------------
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_AW,
        W_W,
        W_RESP
    } wr_state_t;

    typedef enum logic {
        R_IDLE,
        R_VALID
    } rd_state_t;

endpackage

// File: rtl/hex7seg_decode.sv
// ---------------------------------------------------------------------------
// hex7seg_decode
// Combinational hex digit to seven-segment pattern, active-high,
// bit order {dp, g, f, e, d, c, b, a}; dp is always off.
// Only built when AXI_REGFILE_HEX7SEG_EN is defined.
//
// Ports:
//   i_nibble  in   4  hex digit 0-F
//   o_seg     out  8  segment pattern
// ---------------------------------------------------------------------------
`ifdef AXI_REGFILE_HEX7SEG_EN
module hex7seg_decode (
    input  logic [3:0] i_nibble,
    output logic [7:0] o_seg
);

    always_comb begin
        o_seg = 8'h00;
        case (i_nibble)
            4'h0: o_seg = 8'h3F;
            4'h1: o_seg = 8'h06;
            4'h2: o_seg = 8'h5B;
            4'h3: o_seg = 8'h4F;
            4'h4: o_seg = 8'h66;
            4'h5: o_seg = 8'h6D;
            4'h6: o_seg = 8'h7D;
            4'h7: o_seg = 8'h07;
            4'h8: o_seg = 8'h7F;
            4'h9: o_seg = 8'h6F;
            4'hA: o_seg = 8'h77;
            4'hB: o_seg = 8'h7C;
            4'hC: o_seg = 8'h39;
            4'hD: o_seg = 8'h5E;
            4'hE: o_seg = 8'h79;
            4'hF: o_seg = 8'h71;
            default: o_seg = 8'h00;
        endcase
    end

endmodule
`endif

// File: rtl/axi_lite_regfile_slave.sv
// ---------------------------------------------------------------------------
// axi_lite_regfile_slave
// AXI4-Lite slave in front of a bank of NUM_REGS registers of DATA_W bits.
// AW and W may arrive in either order or together; byte strobes select the
// bytes written. Out-of-range accesses answer SLVERR without side effects.
// The data of the latest completed read is kept on o_last_rdata and shown
// on o_disp_hex.
//
// Optional feature macro: AXI_REGFILE_HEX7SEG_EN
//   defined   : o_disp_hex = registered 7-segment decode of last_rdata[3:0]
//   undefined : o_disp_hex = last_rdata[7:0]
//
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_s_aw*/o_s_awready          write address channel
//   i_s_w*/o_s_wready            write data channel (with byte strobes)
//   o_s_b*/i_s_bready            write response channel
//   i_s_ar*/o_s_arready          read address channel
//   o_s_r*/i_s_rready            read data channel
//   o_last_rdata                 data of the most recent R handshake
//   o_disp_hex                   display pattern
//
// Write FSM
//   state  | meaning
//   W_IDLE | waiting for AW and/or W
//   W_AW   | address held, waiting for W
//   W_W    | data and strobes held, waiting for AW
//   W_RESP | B response presented, waiting for bready
// Read FSM
//   state   | meaning
//   R_IDLE  | waiting for AR
//   R_VALID | R presented, waiting for rready
// ---------------------------------------------------------------------------
module axi_lite_regfile_slave
    import axi_lite_pkg::*;
#(
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [ADDR_W-1:0]     i_s_awaddr,
    input  logic                  i_s_awvalid,
    output logic                  o_s_awready,
    input  logic [DATA_W-1:0]     i_s_wdata,
    input  logic [DATA_W/8-1:0]   i_s_wstrb,
    input  logic                  i_s_wvalid,
    output logic                  o_s_wready,
    output logic [1:0]            o_s_bresp,
    output logic                  o_s_bvalid,
    input  logic                  i_s_bready,
    input  logic [ADDR_W-1:0]     i_s_araddr,
    input  logic                  i_s_arvalid,
    output logic                  o_s_arready,
    output logic [DATA_W-1:0]     o_s_rdata,
    output logic [1:0]            o_s_rresp,
    output logic                  o_s_rvalid,
    input  logic                  i_s_rready,
    output logic [DATA_W-1:0]     o_last_rdata,
    output logic [7:0]            o_disp_hex
);

    localparam int STRB_W = DATA_W / 8;
    localparam logic [ADDR_W:0] NUM_REGS_L = (ADDR_W + 1)'(NUM_REGS);

    wr_state_t            r_wstate;
    rd_state_t            r_rstate;
    logic [DATA_W-1:0]    r_regs [NUM_REGS];
    logic [ADDR_W-1:0]    r_aw_addr;
    logic [DATA_W-1:0]    r_wdata;
    logic [STRB_W-1:0]    r_wstrb;
    logic                 r_bvalid;
    logic [1:0]           r_bresp;
    logic                 r_rvalid;
    logic [1:0]           r_rresp;
    logic [DATA_W-1:0]    r_rdata;
    logic [DATA_W-1:0]    r_last_rdata;

    logic                 w_awready;
    logic                 w_wready;
    logic                 w_arready;
    logic                 w_aw_hs;
    logic                 w_w_hs;
    logic                 w_ar_hs;
    logic                 w_commit;
    logic [ADDR_W-1:0]    w_c_addr;
    logic [DATA_W-1:0]    w_c_data;
    logic [STRB_W-1:0]    w_c_strb;
    logic [DATA_W-1:0]    w_rd_word;

    function automatic logic in_range(input logic [ADDR_W-1:0] addr);
        return {1'b0, addr} < NUM_REGS_L;
    endfunction

    // Readys are pure decodes of state, gated by reset so nothing can
    // handshake while rst is high.
    assign w_awready = ~i_rst & ((r_wstate == W_IDLE) || (r_wstate == W_W));
    assign w_wready  = ~i_rst & ((r_wstate == W_IDLE) || (r_wstate == W_AW));
    assign w_arready = ~i_rst & (r_rstate == R_IDLE);

    assign w_aw_hs = i_s_awvalid & w_awready;
    assign w_w_hs  = i_s_wvalid  & w_wready;
    assign w_ar_hs = i_s_arvalid & w_arready;

    // Commit operands: whichever half already arrived comes from the
    // holding registers, the other half straight from the bus.
    assign w_c_addr = (r_wstate == W_AW) ? r_aw_addr : i_s_awaddr;
    assign w_c_data = (r_wstate == W_W)  ? r_wdata   : i_s_wdata;
    assign w_c_strb = (r_wstate == W_W)  ? r_wstrb   : i_s_wstrb;

    always_comb begin
        w_commit = 1'b0;
        case (r_wstate)
            W_IDLE:  w_commit = w_aw_hs & w_w_hs;
            W_AW:    w_commit = w_w_hs;
            W_W:     w_commit = w_aw_hs;
            default: w_commit = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wstate  <= W_IDLE;
            r_aw_addr <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
        end else if (w_commit) begin
            r_bvalid <= 1'b1;
            r_bresp  <= in_range(w_c_addr) ? RESP_OKAY : RESP_SLVERR;
            r_wstate <= W_RESP;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    if (w_aw_hs) begin
                        r_aw_addr <= i_s_awaddr;
                        r_wstate  <= W_AW;
                    end else if (w_w_hs) begin
                        r_wdata  <= i_s_wdata;
                        r_wstrb  <= i_s_wstrb;
                        r_wstate <= W_W;
                    end
                end
                W_RESP: begin
                    if (i_s_bready) begin
                        r_bvalid <= 1'b0;
                        r_wstate <= W_IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    // Address decode by comparison rather than indexing keeps out-of-range
    // addresses from aliasing onto implemented registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_commit) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                for (int b = 0; b < STRB_W; b++) begin
                    if ((w_c_addr == ADDR_W'(i)) && w_c_strb[b]) begin
                        r_regs[i][8*b +: 8] <= w_c_data[8*b +: 8];
                    end
                end
            end
        end
    end

    always_comb begin
        w_rd_word = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (i_s_araddr == ADDR_W'(i)) begin
                w_rd_word = r_regs[i];
            end
        end
    end

    // Capture happens on the AR edge from the current register contents, so
    // a write committing on the same edge is not yet visible.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rstate     <= R_IDLE;
            r_rvalid     <= 1'b0;
            r_rdata      <= '0;
            r_rresp      <= RESP_OKAY;
            r_last_rdata <= '0;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (w_ar_hs) begin
                        r_rdata  <= w_rd_word;
                        r_rresp  <= in_range(i_s_araddr) ? RESP_OKAY : RESP_SLVERR;
                        r_rvalid <= 1'b1;
                        r_rstate <= R_VALID;
                    end
                end
                R_VALID: begin
                    if (i_s_rready) begin
                        r_rvalid     <= 1'b0;
                        r_last_rdata <= r_rdata;
                        r_rstate     <= R_IDLE;
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    assign o_s_awready  = w_awready;
    assign o_s_wready   = w_wready;
    assign o_s_arready  = w_arready;
    assign o_s_bvalid   = r_bvalid;
    assign o_s_bresp    = r_bresp;
    assign o_s_rvalid   = r_rvalid;
    assign o_s_rdata    = r_rdata;
    assign o_s_rresp    = r_rresp;
    assign o_last_rdata = r_last_rdata;

`ifdef AXI_REGFILE_HEX7SEG_EN
    logic [7:0] w_seg;
    logic [7:0] r_disp_hex;

    hex7seg_decode u_hex7seg_decode (
        .i_nibble (r_last_rdata[3:0]),
        .o_seg    (w_seg)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_disp_hex <= 8'h3F;
        end else begin
            r_disp_hex <= w_seg;
        end
    end

    assign o_disp_hex = r_disp_hex;
`else
    assign o_disp_hex = r_last_rdata[7:0];
`endif

endmodule

// File: tb/tb_axi_lite_regfile_slave.sv
// ---------------------------------------------------------------------------
// tb_axi_lite_regfile_slave
// Directed bench for axi_lite_regfile_slave configured with 16-bit data and
// 8 implemented registers out of a 16-entry address space.
// ---------------------------------------------------------------------------
module tb_axi_lite_regfile_slave;

    localparam int AW = 4;
    localparam int DW = 16;
    localparam int NR = 8;
    localparam int SW = DW / 8;

`ifdef AXI_REGFILE_HEX7SEG_EN
    localparam logic [7:0] DISP_RESET = 8'h3F;
    localparam logic [7:0] DISP_0B    = 8'h7C;
`else
    localparam logic [7:0] DISP_RESET = 8'h00;
    localparam logic [7:0] DISP_0B    = 8'h0B;
`endif

    logic          clk;
    logic          rst;
    logic [AW-1:0] awaddr;
    logic          awvalid;
    logic          awready;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
    logic          wvalid;
    logic          wready;
    logic [1:0]    bresp;
    logic          bvalid;
    logic          bready;
    logic [AW-1:0] araddr;
    logic          arvalid;
    logic          arready;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    logic          rvalid;
    logic          rready;
    logic [DW-1:0] last_rdata;
    logic [7:0]    disp_hex;

    int checks;
    int errors;

    axi_lite_regfile_slave #(
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .NUM_REGS (NR)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_s_awaddr   (awaddr),
        .i_s_awvalid  (awvalid),
        .o_s_awready  (awready),
        .i_s_wdata    (wdata),
        .i_s_wstrb    (wstrb),
        .i_s_wvalid   (wvalid),
        .o_s_wready   (wready),
        .o_s_bresp    (bresp),
        .o_s_bvalid   (bvalid),
        .i_s_bready   (bready),
        .i_s_araddr   (araddr),
        .i_s_arvalid  (arvalid),
        .o_s_arready  (arready),
        .o_s_rdata    (rdata),
        .o_s_rresp    (rresp),
        .o_s_rvalid   (rvalid),
        .i_s_rready   (rready),
        .o_last_rdata (last_rdata),
        .o_disp_hex   (disp_hex)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Same-cycle AW+W, then accept B. ok=0 if no B within the budget.
    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [SW-1:0] s, output logic [1:0] resp,
                            output bit ok);
        ok = 1'b0;
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1;
        tick;
        awvalid = 1'b0; wvalid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (bvalid) begin
                ok = 1'b1;
                break;
            end
            tick;
        end
        resp = bresp;
        bready = 1'b1;
        tick;
        bready = 1'b0;
    endtask

    task automatic do_read(input logic [AW-1:0] a, output logic [DW-1:0] d,
                           output logic [1:0] resp, output bit ok);
        ok = 1'b0;
        araddr = a;
        arvalid = 1'b1;
        tick;
        arvalid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (rvalid) begin
                ok = 1'b1;
                break;
            end
            tick;
        end
        d = rdata;
        resp = rresp;
        rready = 1'b1;
        tick;
        rready = 1'b0;
    endtask

    task automatic test_reset;
        logic [DW-1:0] d;
        logic [1:0]    r;
        bit            ok;
        rst = 1'b1;
        awaddr = 4'd0; wdata = 16'hFFFF; wstrb = 2'b11;
        awvalid = 1'b1; wvalid = 1'b1;
        araddr = 4'd0; arvalid = 1'b1;
        tick;
        tick;
        checks++;
        if ({awready, wready, arready} !== 3'b000) begin
            errors++;
            $display("FAIL reset_readys got %b want 000", {awready, wready, arready});
        end
        rst = 1'b0;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        tick;
        checks++;
        if (bvalid !== 1'b0 || rvalid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valids got b=%b r=%b want 0 0", bvalid, rvalid);
        end
        checks++;
        if (rdata !== 16'h0000 || last_rdata !== 16'h0000 || bresp !== 2'b00 || rresp !== 2'b00) begin
            errors++;
            $display("FAIL reset_data got rdata=%h last=%h bresp=%b rresp=%b want 0", rdata, last_rdata, bresp, rresp);
        end
        checks++;
        if (disp_hex !== DISP_RESET) begin
            errors++;
            $display("FAIL reset_disp got %h want %h", disp_hex, DISP_RESET);
        end
        checks++;
        if ({awready, wready, arready} !== 3'b111) begin
            errors++;
            $display("FAIL idle_readys got %b want 111", {awready, wready, arready});
        end
        do_read(4'd0, d, r, ok);
        checks++;
        if (!ok || d !== 16'h0000) begin
            errors++;
            $display("FAIL reset_no_write got ok=%0d data=%h want 1 0000", ok, d);
        end
    endtask

    task automatic test_same_cycle_write;
        awaddr = 4'd3; wdata = 16'h00A5; wstrb = 2'b01;
        awvalid = 1'b1; wvalid = 1'b1;
        tick;
        awvalid = 1'b0; wvalid = 1'b0;
        checks++;
        if (bvalid !== 1'b1 || bresp !== 2'b00) begin
            errors++;
            $display("FAIL write3_b got bvalid=%b bresp=%b want 1 00", bvalid, bresp);
        end
        bready = 1'b1;
        tick;
        bready = 1'b0;
        checks++;
        if (bvalid !== 1'b0) begin
            errors++;
            $display("FAIL write3_b_done got bvalid=%b want 0", bvalid);
        end
        araddr = 4'd3; arvalid = 1'b1;
        tick;
        arvalid = 1'b0;
        checks++;
        if (rvalid !== 1'b1 || rdata !== 16'h00A5 || rresp !== 2'b00 || arready !== 1'b0) begin
            errors++;
            $display("FAIL read3 got rvalid=%b rdata=%h rresp=%b arready=%b want 1 00a5 00 0",
                     rvalid, rdata, rresp, arready);
        end
        rready = 1'b1;
        tick;
        rready = 1'b0;
        checks++;
        if (rvalid !== 1'b0 || last_rdata !== 16'h00A5) begin
            errors++;
            $display("FAIL read3_last got rvalid=%b last=%h want 0 00a5", rvalid, last_rdata);
        end
    endtask

    task automatic test_split_order;
        logic [DW-1:0] d;
        logic [1:0]    r;
        bit            ok;
        wdata = 16'h005C; wstrb = 2'b11; wvalid = 1'b1;
        tick;
        wvalid = 1'b0;
        checks++;
        if (wready !== 1'b0 || awready !== 1'b1 || bvalid !== 1'b0) begin
            errors++;
            $display("FAIL w_first_readys got wready=%b awready=%b bvalid=%b want 0 1 0", wready, awready, bvalid);
        end
        wdata = 16'hDEAD;
        tick;
        tick;
        awaddr = 4'd7; awvalid = 1'b1;
        tick;
        awvalid = 1'b0;
        checks++;
        if (bvalid !== 1'b1 || bresp !== 2'b00) begin
            errors++;
            $display("FAIL w_first_b got bvalid=%b bresp=%b want 1 00", bvalid, bresp);
        end
        bready = 1'b1;
        tick;
        bready = 1'b0;
        do_read(4'd7, d, r, ok);
        checks++;
        if (!ok || d !== 16'h005C || r !== 2'b00) begin
            errors++;
            $display("FAIL w_first_reg7 got ok=%0d data=%h resp=%b want 1 005c 00", ok, d, r);
        end
        awaddr = 4'd5; awvalid = 1'b1;
        tick;
        awvalid = 1'b0;
        awaddr = 4'd6;
        checks++;
        if (awready !== 1'b0 || wready !== 1'b1) begin
            errors++;
            $display("FAIL aw_first_readys got awready=%b wready=%b want 0 1", awready, wready);
        end
        tick;
        wdata = 16'h1234; wstrb = 2'b11; wvalid = 1'b1;
        tick;
        wvalid = 1'b0;
        bready = 1'b1;
        tick;
        bready = 1'b0;
        do_read(4'd5, d, r, ok);
        checks++;
        if (!ok || d !== 16'h1234) begin
            errors++;
            $display("FAIL aw_first_reg5 got ok=%0d data=%h want 1 1234", ok, d);
        end
    endtask

    task automatic test_out_of_range;
        logic [DW-1:0] d;
        logic [1:0]    r;
        bit            ok;
        do_write(4'd15, 16'hBEEF, 2'b11, r, ok);
        checks++;
        if (!ok || r !== 2'b10) begin
            errors++;
            $display("FAIL oor_write15 got ok=%0d bresp=%b want 1 10", ok, r);
        end
        do_write(4'd8, 16'hCAFE, 2'b11, r, ok);
        checks++;
        if (!ok || r !== 2'b10) begin
            errors++;
            $display("FAIL oor_write8 got ok=%0d bresp=%b want 1 10", ok, r);
        end
        do_read(4'd7, d, r, ok);
        checks++;
        if (!ok || d !== 16'h005C || r !== 2'b00) begin
            errors++;
            $display("FAIL oor_no_alias7 got ok=%0d data=%h resp=%b want 1 005c 00", ok, d, r);
        end
        do_read(4'd0, d, r, ok);
        checks++;
        if (!ok || d !== 16'h0000) begin
            errors++;
            $display("FAIL oor_no_alias0 got ok=%0d data=%h want 1 0000", ok, d);
        end
        do_read(4'd12, d, r, ok);
        checks++;
        if (!ok || d !== 16'h0000 || r !== 2'b10) begin
            errors++;
            $display("FAIL oor_read12 got ok=%0d data=%h resp=%b want 1 0000 10", ok, d, r);
        end
    endtask

    task automatic test_backpressure;
        logic [DW-1:0] held;
        awaddr = 4'd1; wdata = 16'h0011; wstrb = 2'b11;
        awvalid = 1'b1; wvalid = 1'b1;
        tick;
        awaddr = 4'd0; wdata = 16'hFFFF;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bvalid !== 1'b1 || bresp !== 2'b00 || awready !== 1'b0 || wready !== 1'b0) begin
                errors++;
                $display("FAIL b_hold cyc %0d got bvalid=%b bresp=%b awready=%b wready=%b want 1 00 0 0",
                         i, bvalid, bresp, awready, wready);
            end
            tick;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        bready = 1'b1;
        tick;
        bready = 1'b0;
        araddr = 4'd1; arvalid = 1'b1;
        tick;
        araddr = 4'd3;
        held = 16'h0011;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (rvalid !== 1'b1 || rdata !== held || rresp !== 2'b00 || arready !== 1'b0) begin
                errors++;
                $display("FAIL r_hold cyc %0d got rvalid=%b rdata=%h rresp=%b arready=%b want 1 %h 00 0",
                         i, rvalid, rdata, rresp, arready, held);
            end
            tick;
        end
        arvalid = 1'b0;
        rready = 1'b1;
        tick;
        rready = 1'b0;
        checks++;
        if (last_rdata !== 16'h0011 || rvalid !== 1'b0) begin
            errors++;
            $display("FAIL r_hold_last got last=%h rvalid=%b want 0011 0", last_rdata, rvalid);
        end
    endtask

    task automatic test_strobes;
        logic [DW-1:0] d;
        logic [1:0]    r;
        bit            ok;
        do_write(4'd2, 16'hFFFF, 2'b11, r, ok);
        do_write(4'd2, 16'h1234, 2'b10, r, ok);
        checks++;
        if (!ok || r !== 2'b00) begin
            errors++;
            $display("FAIL strb_bresp got ok=%0d bresp=%b want 1 00", ok, r);
        end
        do_read(4'd2, d, r, ok);
        checks++;
        if (!ok || d !== 16'h12FF) begin
            errors++;
            $display("FAIL strb_hi got ok=%0d data=%h want 1 12ff", ok, d);
        end
        do_write(4'd2, 16'hAB56, 2'b01, r, ok);
        do_write(4'd2, 16'h5555, 2'b00, r, ok);
        do_read(4'd2, d, r, ok);
        checks++;
        if (!ok || d !== 16'h1256) begin
            errors++;
            $display("FAIL strb_lo_none got ok=%0d data=%h want 1 1256", ok, d);
        end
    endtask

    task automatic test_same_edge;
        logic [DW-1:0] d;
        logic [1:0]    r;
        bit            ok;
        do_write(4'd2, 16'h0011, 2'b11, r, ok);
        awaddr = 4'd2; wdata = 16'h0077; wstrb = 2'b11;
        awvalid = 1'b1; wvalid = 1'b1;
        araddr = 4'd2; arvalid = 1'b1;
        tick;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        checks++;
        if (rvalid !== 1'b1 || rdata !== 16'h0011 || bvalid !== 1'b1) begin
            errors++;
            $display("FAIL same_edge got rvalid=%b rdata=%h bvalid=%b want 1 0011 1", rvalid, rdata, bvalid);
        end
        bready = 1'b1; rready = 1'b1;
        tick;
        bready = 1'b0; rready = 1'b0;
        do_read(4'd2, d, r, ok);
        checks++;
        if (!ok || d !== 16'h0077) begin
            errors++;
            $display("FAIL same_edge_after got ok=%0d data=%h want 1 0077", ok, d);
        end
    endtask

    task automatic test_disp;
        logic [DW-1:0] d;
        logic [1:0]    r;
        bit            ok;
        do_write(4'd4, 16'h000B, 2'b11, r, ok);
        do_read(4'd4, d, r, ok);
        tick;
        checks++;
        if (last_rdata !== 16'h000B || disp_hex !== DISP_0B) begin
            errors++;
            $display("FAIL disp got last=%h disp=%h want 000b %h", last_rdata, disp_hex, DISP_0B);
        end
    endtask

    task automatic test_reset_mid;
        logic [DW-1:0] d;
        logic [1:0]    r;
        bit            ok;
        awaddr = 4'd6; wdata = 16'hABCD; wstrb = 2'b11;
        awvalid = 1'b1; wvalid = 1'b1;
        araddr = 4'd2; arvalid = 1'b1;
        tick;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        checks++;
        if (bvalid !== 1'b1 || rvalid !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre got bvalid=%b rvalid=%b want 1 1", bvalid, rvalid);
        end
        rst = 1'b1; bready = 1'b1; rready = 1'b1;
        tick;
        checks++;
        if (bvalid !== 1'b0 || rvalid !== 1'b0 || last_rdata !== 16'h0000) begin
            errors++;
            $display("FAIL mid_reset got bvalid=%b rvalid=%b last=%h want 0 0 0000", bvalid, rvalid, last_rdata);
        end
        rst = 1'b0; bready = 1'b0; rready = 1'b0;
        tick;
        checks++;
        if (bvalid !== 1'b0 || rvalid !== 1'b0) begin
            errors++;
            $display("FAIL mid_no_resp got bvalid=%b rvalid=%b want 0 0", bvalid, rvalid);
        end
        do_read(4'd2, d, r, ok);
        checks++;
        if (!ok || d !== 16'h0000) begin
            errors++;
            $display("FAIL mid_reg2 got ok=%0d data=%h want 1 0000", ok, d);
        end
        do_read(4'd6, d, r, ok);
        checks++;
        if (!ok || d !== 16'h0000) begin
            errors++;
            $display("FAIL mid_reg6 got ok=%0d data=%h want 1 0000", ok, d);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
        bready = 1'b0; araddr = '0; arvalid = 1'b0; rready = 1'b0;
        test_reset;
        test_same_cycle_write;
        test_split_order;
        test_out_of_range;
        test_backpressure;
        test_strobes;
        test_same_edge;
        test_disp;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
